// File: rtl/wb_write_arbiter_pkg.sv
// Shared definitions for the write-back port arbiter.
// Holds the default buffer depth and starvation limit, plus the pending
// result entry layout used by the buffer and the arbiter.
package wb_write_arbiter_pkg;

  localparam int WB_DEPTH_DEF        = 2;
  localparam int WB_STARVE_LIMIT_DEF = 4;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending multi-cycle-unit result buffer.
// FIFO of wb_entry_t with per-entry invalidation by destination register.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   push/push_rd/push_data enqueue a new valid entry at the tail
//   pop                   dequeue the head entry
//   inv_en/inv_rd         clear valid on every entry whose rd matches
//   head                  entry at the read pointer
//   full, empty           occupancy flags from the registered count
//   valid_vec, rd_vec     per-slot valid bits and destination registers
module wb_pend_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [4:0]            push_rd,
  input  logic [31:0]           push_data,
  input  logic                  pop,
  input  logic                  inv_en,
  input  logic [4:0]            inv_rd,
  output wb_entry_t             head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH-1:0]      valid_vec,
  output logic [DEPTH-1:0][4:0] rd_vec
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  wb_entry_t      mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           push_ok;
  logic           pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    valid_vec = '0;
    rd_vec    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = mem[i].valid;
      rd_vec[i]    = mem[i].rd;
    end
  end

  // A freshly pushed slot takes priority over invalidation, so a result
  // enqueued alongside a matching pipeline write stays valid. Popped slots
  // drop their valid bit so only live entries ever show as valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].valid <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_ok && (wr_ptr == PW'(i))) begin
          mem[i] <= '{valid: 1'b1, rd: push_rd, data: push_data};
        end else if (pop_ok && (rd_ptr == PW'(i))) begin
          mem[i].valid <= 1'b0;
        end else if (inv_en && (mem[i].rd == inv_rd)) begin
          mem[i].valid <= 1'b0;
        end
      end
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter between the WB stage and a multi-cycle
// unit (MDU). The pipeline always wins; MDU results wait in wb_pend_fifo
// and drain on free cycles. Long starvation raises a bubble request.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   pipe_regwrite/pipe_rd/pipe_wdata  WB-stage write request
//   mdu_valid/mdu_rd/mdu_wdata        MDU result, accepted when mdu_ready
//   mdu_ready                         buffer has room
//   rf_we/rf_waddr/rf_wdata           register-file write port
//   stall_req                         ask the hazard unit for one WB bubble
//   busy_mask                         registers with a pending buffered write
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH        = WB_DEPTH_DEF,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_regwrite,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_wdata,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_wdata,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_req,
  output logic [31:0] busy_mask
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  wb_entry_t             head;
  logic                  full;
  logic                  empty;
  logic [DEPTH-1:0]      valid_vec;
  logic [DEPTH-1:0][4:0] rd_vec;
  logic                  pipe_eff;
  logic                  push;
  logic                  pop;
  logic                  head_valid;
  logic                  lose;
  logic [SW-1:0]         starve_cnt;

  assign mdu_ready  = !full;
  assign push       = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
  assign pipe_eff   = pipe_regwrite && (pipe_rd != 5'd0);
  assign head_valid = !empty && head.valid;
  // Stale (invalidated) heads pop regardless of the pipeline; they never
  // need the write port.
  assign pop        = !empty && (!head.valid || !pipe_eff);
  assign lose       = head_valid && pipe_eff;

  wb_pend_fifo #(.DEPTH(DEPTH)) u_pend_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_rd   (mdu_rd),
    .push_data (mdu_wdata),
    .pop       (pop),
    .inv_en    (pipe_eff),
    .inv_rd    (pipe_rd),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .valid_vec (valid_vec),
    .rd_vec    (rd_vec)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (pipe_eff) begin
      rf_we    = 1'b1;
      rf_waddr = pipe_rd;
      rf_wdata = pipe_wdata;
    end else if (head_valid) begin
      rf_we    = 1'b1;
      rf_waddr = head.rd;
      rf_wdata = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (pop || empty) begin
      starve_cnt <= '0;
    end else if (lose && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign stall_req = head_valid && (starve_cnt == STARVE_MAX);

  always_comb begin
    busy_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_vec[i]) busy_mask[rd_vec[i]] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_wb_write_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        pipe_regwrite;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wdata;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_wdata;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic [31:0] busy_mask;

  wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk           (clk),
    .rst           (rst),
    .pipe_regwrite (pipe_regwrite),
    .pipe_rd       (pipe_rd),
    .pipe_wdata    (pipe_wdata),
    .mdu_valid     (mdu_valid),
    .mdu_rd        (mdu_rd),
    .mdu_wdata     (mdu_wdata),
    .mdu_ready     (mdu_ready),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .stall_req     (stall_req),
    .busy_mask     (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        vld;
    bit [4:0]  rd;
    bit [31:0] data;
  } ent_t;

  ent_t q[$];
  int   starve;
  int   n_chk;
  int   n_pass;
  bit   last_accept;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // One clock cycle: drive inputs after the falling edge, compare outputs
  // against the model, then advance the model to the state after the
  // next rising edge.
  task automatic step(input bit r, input bit prw, input bit [4:0] prd, input bit [31:0] pwd,
                      input bit mv, input bit [4:0] mrd, input bit [31:0] mwd);
    int  size;
    bit  eff;
    bit  hv;
    bit  acc;
    bit  pop;
    bit  e_we;
    bit  [4:0]  e_addr;
    bit  [31:0] e_data;
    bit  [31:0] e_busy;
    @(negedge clk);
    rst = r; pipe_regwrite = prw; pipe_rd = prd; pipe_wdata = pwd;
    mdu_valid = mv; mdu_rd = mrd; mdu_wdata = mwd;
    #1;
    size = q.size();
    eff  = prw && (prd != 0);
    hv   = (size > 0) && q[0].vld;
    acc  = mv && (size < DEPTH);
    last_accept = acc && !r;
    if (!r) begin
      e_we = 0; e_addr = 0; e_data = 0;
      if (eff) begin
        e_we = 1; e_addr = prd; e_data = pwd;
      end else if (hv) begin
        e_we = 1; e_addr = q[0].rd; e_data = q[0].data;
      end
      e_busy = 0;
      foreach (q[i]) if (q[i].vld) e_busy[q[i].rd] = 1'b1;
      e_busy[0] = 1'b0;
      chk("rf_we",     64'(rf_we),     64'(e_we));
      chk("rf_waddr",  64'(rf_waddr),  64'(e_addr));
      chk("rf_wdata",  64'(rf_wdata),  64'(e_data));
      chk("mdu_ready", 64'(mdu_ready), 64'(size < DEPTH));
      chk("stall_req", 64'(stall_req), 64'(hv && (starve == STARVE_LIMIT)));
      chk("busy_mask", 64'(busy_mask), 64'(e_busy));
    end
    if (r) begin
      q.delete();
      starve = 0;
    end else begin
      pop = (size > 0) && (!q[0].vld || !eff);
      if (pop || size == 0) starve = 0;
      else if (hv && eff && starve < STARVE_LIMIT) starve++;
      if (pop) void'(q.pop_front());
      if (eff) foreach (q[i]) if (q[i].rd == prd) q[i].vld = 0;
      if (acc && mrd != 0) q.push_back('{vld: 1'b1, rd: mrd, data: mwd});
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; starve = 0; last_accept = 0;
    rst = 1; pipe_regwrite = 0; pipe_rd = 0; pipe_wdata = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_wdata = 0;

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle();

    // Single MDU result, one-cycle latency and busy bit in between.
    step(0, 0, 0, 0, 1, 5, 32'h1234);
    @(negedge clk); #1;
    chk("busy5_pending", 64'(busy_mask), 64'h20);
    chk("mdu_wr_addr",   64'(rf_waddr),  64'd5);
    idle();
    idle();
    chk("busy5_cleared", 64'(busy_mask), 64'h0);

    // Starvation: one buffered entry, six pipeline writes, then a gap.
    step(0, 0, 0, 0, 1, 9, 32'h99);
    for (int i = 0; i < 6; i++) step(0, 1, 3, 32'h300 + i, 0, 0, 0);
    idle();
    idle();

    // Fill the buffer with the pipeline busy, hold a third result.
    step(0, 1, 1, 32'h11, 1, 10, 32'hA0);
    step(0, 1, 1, 32'h12, 1, 11, 32'hB0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 32'h13, 1, 12, 32'hC0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 1, 12, 32'hC0);
      if (last_accept) break;
    end
    for (int i = 0; i < 3; i++) idle();

    // Younger pipeline write kills the buffered one to the same register.
    step(0, 1, 1, 32'h1, 1, 7, 32'hAAAA);
    step(0, 1, 7, 32'hBBBB, 0, 0, 0);
    idle();
    idle();

    // Writes to register 0 are ignored on both sides.
    step(0, 1, 2, 32'h2, 1, 4, 32'h44);
    step(0, 1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
    idle();
    idle();

    // Reset with two entries buffered.
    step(0, 1, 1, 32'h1, 1, 13, 32'hD0);
    step(0, 1, 1, 32'h1, 1, 14, 32'hE0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle();
    idle();

    // Random traffic with a narrow register range to force collisions.
    for (int n = 0; n < 3000; n++) begin
      bit        r;
      bit        prw;
      bit        mv;
      bit [4:0]  prd;
      bit [4:0]  mrd;
      r   = ($urandom_range(0, 99) == 0);
      prw = ($urandom_range(0, 99) < 60);
      mv  = ($urandom_range(0, 99) < 50);
      prd = 5'($urandom_range(0, 7));
      mrd = 5'($urandom_range(0, 7));
      step(r, prw, prd, $urandom, mv, mrd, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
